dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the pipeline MEM stage (core)
//  and a loader/debug master (ldr) using a req/gnt handshake.
//  The core has priority. A starvation counter forces loader ownership and
//  stalls the core. Sits between the MEM stage and the data memory; muxes
//  addr/wdata/we/funct3 to the memory and returns read data to the owner.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive blocked loader cycles before a forced loader window (>=1)
//  MAX_BURST     8   max loader grants per forced window (>=1)
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   synchronous reset, active-high
//  core_req    in   1   MEM stage has a load/store this cycle
//  core_we     in   1   core store (1) / load (0)
//  core_addr   in   32  core byte address
//  core_wdata  in   32  core store data
//  core_funct3 in   3   core width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  core_rdata  out  32  memory read data, combinational, valid when core_stall=0
//  core_stall  out  1   core must hold MEM stage this cycle
//  ldr_req     in   1   loader request; held with stable fields until ldr_gnt
//  ldr_lock    in   1   loader asks to keep ownership for back-to-back ops
//  ldr_we, ldr_addr[31:0], ldr_wdata[31:0], ldr_funct3[2:0]  in  loader op fields
//  ldr_gnt     out  1   loader op performed this cycle (write commits at this edge)
//  ldr_rdata   out  32  registered loader read data
//  ldr_rvalid  out  1   1-cycle pulse, cycle after a loader read grant
//  mem_addr, mem_wdata[31:0], mem_funct3[2:0]  out  to data memory
//  mem_we      out  1   memory write enable
//  mem_rdata   in   32  from data memory (combinational read)
// BEHAVIOUR
//  - FSM states: S_CORE (reset), S_LDR. Counters: wait_cnt, burst_cnt; both reset to 0.
//  - Reset values: ldr_rdata=0 and ldr_rvalid=0. While rst=1: mem_we=0, ldr_gnt=0,
//    core_stall=0. Reset mid-window returns to S_CORE and drops pending state.
//  - S_CORE, core_req=1: core owns the port. ldr_gnt=0, core_stall=0.
//    If ldr_req=1, wait_cnt++ (saturating). If wait_cnt==STARVE_LIMIT-1 that
//    cycle: next state S_LDR, wait_cnt<=0.
//  - S_CORE, core_req=0 and ldr_req=1: loader is served the same cycle.
//    ldr_gnt=1, wait_cnt<=0.
//  - S_CORE, ldr_req=0: wait_cnt<=0.
//  - S_LDR: loader owns the port. core_stall=core_req. ldr_gnt=ldr_req.
//    Each grant does burst_cnt++.
//  - Exit S_LDR -> S_CORE (burst_cnt<=0) at the edge when any of these holds:
//    ldr_req=0; ldr_lock=0 after a grant; grant with burst_cnt==MAX_BURST-1.
//  - With ldr_lock=0 the window is exactly one grant. The core is stalled for
//    at most MAX_BURST consecutive cycles per window.
//  - Mux: mem_* takes the owner's fields. mem_we=owner_we & owner_req & ~rst.
//    With no owner: mem_we=0 and fields come from the core.
//  - Loader read grant: ldr_rdata<=mem_rdata and ldr_rvalid<=1 at that edge.
//    Otherwise ldr_rvalid<=0 and ldr_rdata holds.
//  - core_rdata=mem_rdata always. The core must ignore it while core_stall=1.
//  - No combinational path from ldr_* to core_stall other than through state.
// TESTING
//  - Reset: rst=1 for 2 cycles with both reqs=1 -> mem_we=0, ldr_gnt=0,
//    ldr_rvalid=0, core_stall=0; state S_CORE after release.
//  - Idle core: core_req=0, ldr write 0xDEADBEEF to 0x10 (SW) -> ldr_gnt=1 the
//    same cycle; a later core LW from 0x10 returns 0xDEADBEEF.
//  - Starvation: core_req=1 continuously, ldr_req=1, STARVE_LIMIT=4 ->
//    ldr_gnt=0 for 4 cycles, then gnt=1 with core_stall=1 in cycle 5, core
//    resumes in cycle 6.
//  - Burst: forced window, ldr_lock=1, 10 queued loader ops, MAX_BURST=8 ->
//    exactly 8 consecutive grants with core stalled, then 1 core cycle.
//  - Loader read: LBU from 0x13 holding word 0x80FF0000 -> ldr_rvalid pulses
//    1 cycle after gnt with ldr_rdata=0x00000080.
//  - Reset mid-window: rst=1 during grant 3 of a burst -> no write that cycle;
//    back in S_CORE with counters 0; core_stall=0 next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single data-memory port between the pipeline MEM stage (core)
//   and a loader/debug master (ldr). The core normally has priority. If the
//   loader is blocked for STARVE_LIMIT consecutive cycles, a forced loader
//   window opens. During that window the core is stalled for at most
//   MAX_BURST loader grants.
//
// Parameters
//   STARVE_LIMIT : consecutive blocked loader cycles before a forced window (>=1)
//   MAX_BURST    : maximum loader grants per forced window (>=1)
//
// Ports
//   clk, rst                     : clock and synchronous active-high reset
//   core_req/we/addr/wdata/funct3: MEM-stage request fields
//   core_rdata                   : memory read data (valid when core_stall=0)
//   core_stall                   : core must hold the MEM stage this cycle
//   ldr_req/lock/we/addr/wdata/funct3 : loader request fields
//   ldr_gnt                      : loader op performed this cycle
//   ldr_rdata, ldr_rvalid        : registered loader read data and its pulse
//   mem_addr/wdata/funct3/we     : fields muxed to the data memory
//   mem_rdata                    : combinational read data from the memory
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_funct3,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        ldr_req,
  input  logic        ldr_lock,
  input  logic        ldr_we,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  input  logic [2:0]  ldr_funct3,
  output logic        ldr_gnt,
  output logic [31:0] ldr_rdata,
  output logic        ldr_rvalid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int WW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    S_CORE = 1'b0,
    S_LDR  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [WW-1:0]   wait_reg, wait_next;
  logic [BW-1:0]   burst_reg, burst_next;
  logic            gnt_next;     // loader granted this cycle (before reset gating)
  logic            core_own;     // core drives the memory this cycle
  logic            stall_next;   // core stall (before reset gating)

  // Next-state and ownership decode
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    burst_next = burst_reg;
    gnt_next   = 1'b0;
    core_own   = 1'b0;
    stall_next = 1'b0;

    case (state_reg)
      S_CORE: begin
        burst_next = '0;
        if (core_req) begin
          core_own = 1'b1;
          if (ldr_req) begin
            // The blocked cycle that reaches the limit opens the window.
            // The counter never counts past WAIT_LAST, so it saturates.
            if (wait_reg == WAIT_LAST) begin
              state_next = S_LDR;
              wait_next  = '0;
            end else begin
              wait_next = wait_reg + 1'b1;
            end
          end else begin
            wait_next = '0;
          end
        end else if (ldr_req) begin
          // The core is idle, so the loader is served in the same cycle.
          gnt_next  = 1'b1;
          wait_next = '0;
        end else begin
          wait_next = '0;
        end
      end

      S_LDR: begin
        // The stall depends only on state and core_req, not on ldr_* inputs.
        stall_next = core_req;
        gnt_next   = ldr_req;
        wait_next  = '0;
        if (!ldr_req || !ldr_lock || (burst_reg == BURST_LAST)) begin
          state_next = S_CORE;
          burst_next = '0;
        end else begin
          burst_next = burst_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_CORE;
        wait_next  = '0;
        burst_next = '0;
      end
    endcase
  end

  // Handshake outputs are forced low while reset is asserted.
  assign ldr_gnt    = gnt_next & ~rst;
  assign core_stall = stall_next & ~rst;

  // The port follows the loader only when it is actually granted.
  // Otherwise it carries the core fields, including the no-owner case.
  assign mem_addr   = gnt_next ? ldr_addr   : core_addr;
  assign mem_wdata  = gnt_next ? ldr_wdata  : core_wdata;
  assign mem_funct3 = gnt_next ? ldr_funct3 : core_funct3;
  assign mem_we     = ~rst & (gnt_next ? ldr_we : (core_own & core_we));

  assign core_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_CORE;
      wait_reg   <= '0;
      burst_reg  <= '0;
      ldr_rdata  <= '0;
      ldr_rvalid <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wait_reg   <= wait_next;
      burst_reg  <= burst_next;
      ldr_rvalid <= gnt_next & ~ldr_we;
      if (gnt_next && !ldr_we) begin
        ldr_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter. A small byte-addressed data memory
//   with LB/LH/LW/LBU/LHU read formatting and SB/SH/SW writes sits behind
//   the port. Expected values are hand-computed per cycle.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_funct3;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        ldr_req, ldr_lock, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata;
  logic [2:0]  ldr_funct3;
  logic        ldr_gnt;
  logic [31:0] ldr_rdata;
  logic        ldr_rvalid;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic        mem_init;
  int          n_vec;
  int          n_err;

  dmem_port_arbiter #(
    .STARVE_LIMIT(4),
    .MAX_BURST   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_funct3(core_funct3),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .ldr_req    (ldr_req),
    .ldr_lock   (ldr_lock),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_funct3 (ldr_funct3),
    .ldr_gnt    (ldr_gnt),
    .ldr_rdata  (ldr_rdata),
    .ldr_rvalid (ldr_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: 64 words, combinational formatted read, write at posedge
  logic [31:0] mem_words [0:63];
  logic [31:0] rd_word, rd_shift;

  always_comb begin
    rd_word  = mem_words[mem_addr[7:2]];
    rd_shift = rd_word >> {mem_addr[1:0], 3'b000};
    case (mem_funct3)
      3'd0:    mem_rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    mem_rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    mem_rdata = {24'h0, rd_shift[7:0]};
      3'd5:    mem_rdata = {16'h0, rd_shift[15:0]};
      default: mem_rdata = rd_word;
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_words[i] <= 32'h0;
    end else if (mem_we) begin
      case (mem_funct3[1:0])
        2'd0:    mem_words[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        2'd1:    mem_words[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        default: mem_words[mem_addr[7:2]] <= mem_wdata;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_all;
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0; core_funct3 = 3'd2;
    ldr_req = 1'b0; ldr_lock = 1'b0; ldr_we = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0; ldr_funct3 = 3'd2;
  endtask

  task automatic core_load(input logic [31:0] a, input logic [2:0] f3);
    core_req = 1'b1; core_we = 1'b0; core_addr = a; core_funct3 = f3;
  endtask

  task automatic ldr_op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_funct3 = f3;
  endtask

  initial begin
    int k;
    logic exp_g;
    n_vec = 0;
    n_err = 0;

    // ---- Reset with both requesters active ----
    idle_all();
    rst = 1'b1; mem_init = 1'b1;
    core_req = 1'b1; core_we = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1; ldr_lock = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst mem_we", 32'(mem_we), 32'h0);
      check("rst ldr_gnt", 32'(ldr_gnt), 32'h0);
      check("rst core_stall", 32'(core_stall), 32'h0);
      check("rst ldr_rvalid", 32'(ldr_rvalid), 32'h0);
    end
    rst = 1'b0; mem_init = 1'b0;
    idle_all();
    // After release the core has priority (S_CORE): loader blocked, no stall
    core_load(32'h10, 3'd2);
    ldr_op(1'b0, 32'h0, 32'h0, 3'd2);
    settle();
    check("post-rst ldr_gnt", 32'(ldr_gnt), 32'h0);
    check("post-rst core_stall", 32'(core_stall), 32'h0);
    tick();
    idle_all();
    tick();

    // ---- Idle core: loader SW 0xDEADBEEF to 0x10, served same cycle ----
    ldr_op(1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
    settle();
    check("idle ldr_gnt", 32'(ldr_gnt), 32'h1);
    check("idle mem_we", 32'(mem_we), 32'h1);
    check("idle mem_addr", mem_addr, 32'h10);
    tick();
    idle_all();
    check("idle write rvalid", 32'(ldr_rvalid), 32'h0);
    core_load(32'h10, 3'd2);
    settle();
    check("core LW 0x10", core_rdata, 32'hDEADBEEF);
    check("core LW stall", 32'(core_stall), 32'h0);
    tick();

    // ---- Core store SH 0xBEEF to 0x22 then LW 0x20 ----
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h22; core_wdata = 32'h0000BEEF; core_funct3 = 3'd1;
    settle();
    check("core SH mem_we", 32'(mem_we), 32'h1);
    tick();
    core_load(32'h20, 3'd2);
    settle();
    check("core LW 0x20", core_rdata, 32'hBEEF0000);
    tick();

    // ---- Starvation: 4 blocked cycles, forced grant in cycle 5 ----
    core_load(32'h10, 3'd2);
    ldr_op(1'b1, 32'h14, 32'hCAFEF00D, 3'd2);
    ldr_lock = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      check($sformatf("starve c%0d gnt", c), 32'(ldr_gnt), 32'h0);
      check($sformatf("starve c%0d stall", c), 32'(core_stall), 32'h0);
      tick();
    end
    settle();
    check("starve c5 gnt", 32'(ldr_gnt), 32'h1);
    check("starve c5 stall", 32'(core_stall), 32'h1);
    check("starve c5 mem_we", 32'(mem_we), 32'h1);
    tick();
    ldr_req = 1'b0;
    core_load(32'h14, 3'd2);
    settle();
    check("starve c6 stall", 32'(core_stall), 32'h0);
    check("starve c6 gnt", 32'(ldr_gnt), 32'h0);
    check("starve c6 LW 0x14", core_rdata, 32'hCAFEF00D);
    tick();

    // ---- Burst: lock=1, 10 queued loader writes, 8 granted ----
    k = 0;
    ldr_lock = 1'b1;
    for (int c = 0; c < 13; c++) begin
      core_load(32'h10, 3'd2);
      ldr_op(1'b1, 32'h40 + 32'(4 * k), 32'h1000 + 32'(k), 3'd2);
      settle();
      exp_g = (c >= 4) && (c <= 11);
      check($sformatf("burst c%0d gnt", c), 32'(ldr_gnt), 32'(exp_g));
      check($sformatf("burst c%0d stall", c), 32'(core_stall), 32'(exp_g));
      if (ldr_gnt) k++;
      tick();
    end
    idle_all();
    check("burst grant total", 32'(k), 32'd8);
    core_load(32'h5C, 3'd2);
    settle();
    check("burst op7 written", core_rdata, 32'h00001007);
    tick();
    core_load(32'h60, 3'd2);
    settle();
    check("burst op8 not written", core_rdata, 32'h0);
    tick();
    idle_all();

    // ---- Loader reads: word 0x80FF0000 at 0x10, LBU/LB from 0x13 ----
    ldr_op(1'b1, 32'h10, 32'h80FF0000, 3'd2);
    tick();
    ldr_op(1'b0, 32'h13, 32'h0, 3'd4);
    settle();
    check("LBU gnt", 32'(ldr_gnt), 32'h1);
    check("LBU mem_we", 32'(mem_we), 32'h0);
    check("LBU rvalid same cycle", 32'(ldr_rvalid), 32'h0);
    tick();
    ldr_req = 1'b0;
    check("LBU rvalid", 32'(ldr_rvalid), 32'h1);
    check("LBU rdata", ldr_rdata, 32'h00000080);
    tick();
    check("LBU rvalid drop", 32'(ldr_rvalid), 32'h0);
    check("LBU rdata hold", ldr_rdata, 32'h00000080);
    ldr_op(1'b0, 32'h13, 32'h0, 3'd0);
    tick();
    ldr_req = 1'b0;
    check("LB rdata", ldr_rdata, 32'hFFFFFF80);
    tick();

    // ---- Reset during grant 3 of a burst ----
    k = 0;
    ldr_lock = 1'b1;
    for (int c = 0; c < 7; c++) begin
      core_load(32'h88, 3'd2);
      ldr_op(1'b1, 32'h80 + 32'(4 * k), 32'h2000 + 32'(k), 3'd2);
      rst = (c == 6);
      settle();
      if (c == 6) begin
        check("rst-win gnt", 32'(ldr_gnt), 32'h0);
        check("rst-win mem_we", 32'(mem_we), 32'h0);
        check("rst-win stall", 32'(core_stall), 32'h0);
      end else begin
        exp_g = (c >= 4);
        check($sformatf("rst-win c%0d gnt", c), 32'(ldr_gnt), 32'(exp_g));
      end
      if (ldr_gnt) k++;
      tick();
    end
    rst = 1'b0;
    // Back in S_CORE with wait counter cleared: 4 blocked cycles again
    for (int c = 0; c < 4; c++) begin
      core_load(32'h88, 3'd2);
      ldr_op(1'b1, 32'h80 + 32'(4 * k), 32'h2000 + 32'(k), 3'd2);
      settle();
      check($sformatf("after-rst c%0d stall", c), 32'(core_stall), 32'h0);
      check($sformatf("after-rst c%0d gnt", c), 32'(ldr_gnt), 32'h0);
      check($sformatf("after-rst c%0d 0x88", c), core_rdata, 32'h0);
      tick();
    end
    ldr_lock = 1'b0;
    settle();
    check("after-rst regrant gnt", 32'(ldr_gnt), 32'h1);
    check("after-rst regrant stall", 32'(core_stall), 32'h1);
    tick();
    idle_all();
    core_load(32'h88, 3'd2);
    settle();
    check("after-rst final stall", 32'(core_stall), 32'h0);
    check("after-rst op2 written", core_rdata, 32'h00002002);
    tick();
    idle_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
